ext_mem_arbiter: RTL and testbench
==================================

Name: ext_mem_arbiter

Overview:
- Shares the single external 8-bit SRAM port among three requesters: the CPU, video fetch and cache-page refill DMA.
- Owns the phi2 slot sequencer: 10 fpgaClk slots per phi2 period, with phi2 low in slots 0-4 and high in slots 5-9.
- Carves each phi2 period into four fixed 2-clock access windows and grants each window by a fixed priority.
- Sits between the CPU/cache address translation and the SRAM pins.

Parameters:
- PHI_DIV, 10, fpgaClk slots per phi2 period.
- PHI2_RISE, 5, first slot in which phi2 is high.
- ADDR_W, 24, external address width.
- RFL_LEN, 4, beats per refill burst (1..16).

Ports:
- fpgaClk  in  1  system clock.
- fpgaRstN  in  1  reset, asynchronous, active-low.
- phi2  out  1  CPU phase-2 clock.
- cpuEn  in  1  CPU requests an access this phi2 period.
- cpuRw  in  1  1=read, 0=write.
- cpuAddr  in  ADDR_W  translated CPU address.
- cpuWdata  in  8  CPU write data.
- cpuRdata  out  8  CPU read data, held until next CPU read.
- vidReq  in  1  video fetch request (level).
- vidAddr  in  ADDR_W  video fetch address.
- vidAck  out  1  one-clock pulse, vidData valid.
- vidData  out  8  video fetch data, held.
- rflReq  in  1  refill burst request (level).
- rflAddr  in  ADDR_W  burst start address.
- rflAck  out  1  one-clock pulse per beat, rflData valid.
- rflDone  out  1  one-clock pulse with the last beat.
- rflData  out  8  refill beat data, held.
- memAddr  out  ADDR_W  SRAM address.
- memDout  out  8  SRAM write data.
- memDin  in  8  SRAM read data.
- memOe  out  1  SRAM output enable.
- memWe  out  1  SRAM write enable.

Behaviour:
- Reset (async, fpgaRstN=0):
  - slot=0, phi2=0; refill idle, beat=0.
  - All outputs 0, including held data registers.
  - Reset mid-burst aborts the burst; no rflDone is issued.
- Slot counter: 0..PHI_DIV-1, wraps to 0. phi2 is registered and equals (slot >= PHI2_RISE).
- Windows (2 clocks each):
  - A = slots 0-1, B = 2-3, C = 5-6, D = 7-8.
  - Slots 4 and 9 are turnaround: memOe=0, memWe=0, memAddr holds.
- Grant decision is registered on the edge entering the window's first slot, using inputs sampled on that edge:
  - A: video if vidReq, else refill if busy or rflReq, else idle.
  - B, D: refill if busy or rflReq, else idle.
  - C: CPU if cpuEn; cpuRw, cpuAddr and cpuWdata are latched. Otherwise refill/idle as for B.
- Access timing:
  - memAddr is driven for both window slots.
  - Read: memOe=1 both slots. memDin is captured on the edge leaving the second slot.
  - Write (CPU only): memDout=cpuWdata both slots; memWe=1 in the second slot only.
- Responses:
  - CPU read: cpuRdata updated on the edge leaving slot 6.
  - Video: vidData updated and vidAck=1 for the clock after the window, i.e. slot 2.
  - Refill: rflData updated and rflAck=1 for the clock after the window.
- Refill burst:
  - Accepted in the first refill-granted window while idle. rflAddr is latched as base; beat=0; busy=1.
  - Beat n address = base+n, modulo 2^ADDR_W, so a top-of-memory start wraps to 0.
  - rflReq and rflAddr are ignored while busy.
  - The last beat (n=RFL_LEN-1) pulses rflDone together with rflAck and clears busy.
  - A new burst can start no earlier than the next window after done.
- Throughput: at most 4 refill beats per phi2 period (3 when cpuEn=1, 2 when vidReq=1 as well).
- Simultaneous events:
  - Video beats refill in A.
  - The CPU always owns C when cpuEn=1, including mid-burst.
  - vidReq dropped before window A sampling means no grant and no vidAck.

Decomposition:
- Package ext_mem_pkg:
  - slot constants (window start slots, turnaround slots);
  - grant enum {GNT_IDLE, GNT_CPU, GNT_VID, GNT_RFL};
  - window enum {WIN_A, WIN_B, WIN_C, WIN_D, WIN_NONE}.
- Sub-module phi2_slot_seq: slot counter, phi2, window/first-slot/second-slot decode. The arbiter datapath and refill FSM stay in ext_mem_arbiter.

Test Plan:
- Reset released, all requests 0 -> phi2 low 5 clocks / high 5 clocks repeating; memOe=memWe=0 throughout.
- cpuEn=1, cpuRw=0, cpuAddr=0x001234, cpuWdata=0xA5 -> memAddr=0x001234 in slots 5-6; memWe=1 only in slot 6. Then a read of the same address returns cpuRdata=0xA5 after slot 6.
- vidReq=1 and rflReq=1 together, rflAddr=0x010000, RFL_LEN=4, cpuEn=1 -> A grants video (vidAck in slot 2). Beats land at 0x010000/1 in B/D of period 1 and 0x010002/3 in B/D of period 2; rflDone coincides with the 4th rflAck.
- rflAddr=0xFFFFFE, RFL_LEN=4, no other requesters -> beat addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001 in windows A, B, C, D of one period.
- Burst active, rflAddr changed to 0x123456 mid-burst -> remaining beats continue from the original base; the new address is only used after rflDone if rflReq is still high.
- fpgaRstN pulsed low after beat 2 -> all outputs 0 immediately, no rflDone. After release, slot restarts at 0 and phi2=0.

Source files
------------

// File: rtl/ext_mem_pkg.sv
// Shared slot map, grant and window types for the external SRAM arbiter.
package ext_mem_pkg;

   localparam int unsigned SlotA     = 0;
   localparam int unsigned SlotB     = 2;
   localparam int unsigned SlotC     = 5;
   localparam int unsigned SlotD     = 7;
   localparam int unsigned SlotTurnLo = 4;
   localparam int unsigned SlotTurnHi = 9;

   typedef enum logic [1:0] {GNT_IDLE, GNT_CPU, GNT_VID, GNT_RFL} grantE;
   typedef enum logic [2:0] {WIN_A, WIN_B, WIN_C, WIN_D, WIN_NONE} windowE;

   function automatic windowE slotWin(input int unsigned s);
      windowE w;
      case (s)
         SlotA, SlotA + 1: w = WIN_A;
         SlotB, SlotB + 1: w = WIN_B;
         SlotC, SlotC + 1: w = WIN_C;
         SlotD, SlotD + 1: w = WIN_D;
         default:          w = WIN_NONE;
      endcase
      return w;
   endfunction

   function automatic logic isFirstSlot(input int unsigned s);
      return (s == SlotA) || (s == SlotB) || (s == SlotC) || (s == SlotD);
   endfunction

endpackage

// File: rtl/phi2_slot_seq.sv
// phi2 slot sequencer: slot counter, registered phi2 and access-window decode.
module phi2_slot_seq
   import ext_mem_pkg::*;
#(
   parameter int unsigned PHI_DIV   = 10,
   parameter int unsigned PHI2_RISE = 5
) (
   input  logic   fpgaClk,
   input  logic   fpgaRstN,
   output logic   phi2,
   output logic   firstSlot,
   output logic   secondSlot,
   output windowE enterWin
);

   localparam int unsigned SlotW = $clog2(PHI_DIV);

   logic [SlotW-1:0] slotQ, slotD;
   logic             phi2Q;
   windowE           win;

   always_comb begin
      slotD = (slotQ == SlotW'(PHI_DIV - 1)) ? '0 : slotQ + 1'b1;
   end

   always_ff @(posedge fpgaClk or negedge fpgaRstN) begin
      if (!fpgaRstN) begin
         slotQ <= '0;
         phi2Q <= 1'b0;
      end else begin
         slotQ <= slotD;
         phi2Q <= (slotD >= SlotW'(PHI2_RISE));
      end
   end

   assign phi2 = phi2Q;

   // enterWin names the window whose first slot begins on the coming edge.
   always_comb begin
      win        = slotWin(32'(slotQ));
      firstSlot  = isFirstSlot(32'(slotQ));
      secondSlot = (win != WIN_NONE) && !firstSlot;
      enterWin   = isFirstSlot(32'(slotD)) ? slotWin(32'(slotD)) : WIN_NONE;
   end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Shares the 8-bit external SRAM between CPU, video fetch and refill DMA
// using four fixed 2-clock windows per phi2 period.
module ext_mem_arbiter
   import ext_mem_pkg::*;
#(
   parameter int unsigned PHI_DIV   = 10,
   parameter int unsigned PHI2_RISE = 5,
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned RFL_LEN   = 4
) (
   input  logic              fpgaClk,
   input  logic              fpgaRstN,
   output logic              phi2,
   input  logic              cpuEn,
   input  logic              cpuRw,
   input  logic [ADDR_W-1:0] cpuAddr,
   input  logic [7:0]        cpuWdata,
   output logic [7:0]        cpuRdata,
   input  logic              vidReq,
   input  logic [ADDR_W-1:0] vidAddr,
   output logic              vidAck,
   output logic [7:0]        vidData,
   input  logic              rflReq,
   input  logic [ADDR_W-1:0] rflAddr,
   output logic              rflAck,
   output logic              rflDone,
   output logic [7:0]        rflData,
   output logic [ADDR_W-1:0] memAddr,
   output logic [7:0]        memDout,
   input  logic [7:0]        memDin,
   output logic              memOe,
   output logic              memWe
);

   localparam int unsigned BeatW = (RFL_LEN > 1) ? $clog2(RFL_LEN) : 1;

   typedef enum logic {RflIdle, RflBusy} rflStateE;

   logic   firstSlot, secondSlot;
   windowE enterWin;

   phi2_slot_seq #(
      .PHI_DIV   (PHI_DIV),
      .PHI2_RISE (PHI2_RISE)
   ) uSlotSeq (
      .fpgaClk    (fpgaClk),
      .fpgaRstN   (fpgaRstN),
      .phi2       (phi2),
      .firstSlot  (firstSlot),
      .secondSlot (secondSlot),
      .enterWin   (enterWin)
   );

   grantE             gntQ, gntD;
   rflStateE          rflStQ, rflStD;
   logic [BeatW-1:0]  beatQ, beatD, beatAfter;
   logic [ADDR_W-1:0] baseQ, baseD, memAddrQ, memAddrD;
   logic [7:0]        memDoutQ, memDoutD, cpuRdataQ, cpuRdataD;
   logic [7:0]        vidDataQ, vidDataD, rflDataQ, rflDataD;
   logic              rwQ, rwD, memOeQ, memOeD, memWeQ, memWeD;
   logic              vidAckQ, vidAckD, rflAckQ, rflAckD, rflDoneQ, rflDoneD;
   logic              capture, rflBeat, rflLast, busyEff;

   // A burst finishing on this edge must not count as busy for the window opening on it.
   always_comb begin
      capture   = secondSlot && (gntQ != GNT_IDLE);
      rflBeat   = secondSlot && (gntQ == GNT_RFL);
      rflLast   = rflBeat && (beatQ == BeatW'(RFL_LEN - 1));
      busyEff   = (rflStQ == RflBusy) && !rflLast;
      beatAfter = rflBeat ? beatQ + 1'b1 : beatQ;
   end

   always_comb begin
      gntD      = gntQ;
      rwD       = rwQ;
      rflStD    = rflStQ;
      beatD     = beatAfter;
      baseD     = baseQ;
      memAddrD  = memAddrQ;
      memDoutD  = memDoutQ;
      memOeD    = 1'b0;
      memWeD    = 1'b0;
      cpuRdataD = cpuRdataQ;
      vidDataD  = vidDataQ;
      rflDataD  = rflDataQ;
      vidAckD   = 1'b0;
      rflAckD   = 1'b0;
      rflDoneD  = 1'b0;

      if (rflLast) begin
         rflStD = RflIdle;
         beatD  = '0;
      end

      if (capture) begin
         case (gntQ)
            GNT_CPU: if (rwQ) cpuRdataD = memDin;
            GNT_VID: begin
               vidDataD = memDin;
               vidAckD  = 1'b1;
            end
            GNT_RFL: begin
               rflDataD = memDin;
               rflAckD  = 1'b1;
               rflDoneD = rflLast;
            end
            default: ;
         endcase
      end

      if (enterWin != WIN_NONE) begin
         gntD = GNT_IDLE;
         if (enterWin == WIN_C && cpuEn)       gntD = GNT_CPU;
         else if (enterWin == WIN_A && vidReq) gntD = GNT_VID;
         else if (busyEff || rflReq)           gntD = GNT_RFL;

         unique case (gntD)
            GNT_CPU: begin
               rwD      = cpuRw;
               memAddrD = cpuAddr;
               memOeD   = cpuRw;
               if (!cpuRw) memDoutD = cpuWdata;
            end
            GNT_VID: begin
               memAddrD = vidAddr;
               memOeD   = 1'b1;
            end
            GNT_RFL: begin
               memOeD = 1'b1;
               if (busyEff) begin
                  memAddrD = baseQ + ADDR_W'(beatAfter);
               end else begin
                  rflStD   = RflBusy;
                  baseD    = rflAddr;
                  beatD    = '0;
                  memAddrD = rflAddr;
               end
            end
            default: ;
         endcase
      end else if (firstSlot) begin
         memOeD = memOeQ;
         memWeD = (gntQ == GNT_CPU) && !rwQ;
      end else begin
         gntD = GNT_IDLE;
      end
   end

   always_ff @(posedge fpgaClk or negedge fpgaRstN) begin
      if (!fpgaRstN) begin
         gntQ      <= GNT_IDLE;
         rwQ       <= 1'b0;
         rflStQ    <= RflIdle;
         beatQ     <= '0;
         baseQ     <= '0;
         memAddrQ  <= '0;
         memDoutQ  <= '0;
         memOeQ    <= 1'b0;
         memWeQ    <= 1'b0;
         cpuRdataQ <= '0;
         vidDataQ  <= '0;
         rflDataQ  <= '0;
         vidAckQ   <= 1'b0;
         rflAckQ   <= 1'b0;
         rflDoneQ  <= 1'b0;
      end else begin
         gntQ      <= gntD;
         rwQ       <= rwD;
         rflStQ    <= rflStD;
         beatQ     <= beatD;
         baseQ     <= baseD;
         memAddrQ  <= memAddrD;
         memDoutQ  <= memDoutD;
         memOeQ    <= memOeD;
         memWeQ    <= memWeD;
         cpuRdataQ <= cpuRdataD;
         vidDataQ  <= vidDataD;
         rflDataQ  <= rflDataD;
         vidAckQ   <= vidAckD;
         rflAckQ   <= rflAckD;
         rflDoneQ  <= rflDoneD;
      end
   end

   assign memAddr  = memAddrQ;
   assign memDout  = memDoutQ;
   assign memOe    = memOeQ;
   assign memWe    = memWeQ;
   assign cpuRdata = cpuRdataQ;
   assign vidData  = vidDataQ;
   assign vidAck   = vidAckQ;
   assign rflData  = rflDataQ;
   assign rflAck   = rflAckQ;
   assign rflDone  = rflDoneQ;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter with a small SRAM model and a slot tracker.
module tb_ext_mem_arbiter;

   localparam int unsigned ADDR_W  = 24;
   localparam int unsigned RFL_LEN = 4;

   logic              fpgaClk, fpgaRstN, phi2;
   logic              cpuEn, cpuRw, vidReq, vidAck, rflReq, rflAck, rflDone, memOe, memWe;
   logic [ADDR_W-1:0] cpuAddr, vidAddr, rflAddr, memAddr;
   logic [7:0]        cpuWdata, cpuRdata, vidData, rflData, memDout, memDin;

   ext_mem_arbiter #(
      .PHI_DIV   (10),
      .PHI2_RISE (5),
      .ADDR_W    (ADDR_W),
      .RFL_LEN   (RFL_LEN)
   ) dut (
      .fpgaClk  (fpgaClk),
      .fpgaRstN (fpgaRstN),
      .phi2     (phi2),
      .cpuEn    (cpuEn),
      .cpuRw    (cpuRw),
      .cpuAddr  (cpuAddr),
      .cpuWdata (cpuWdata),
      .cpuRdata (cpuRdata),
      .vidReq   (vidReq),
      .vidAddr  (vidAddr),
      .vidAck   (vidAck),
      .vidData  (vidData),
      .rflReq   (rflReq),
      .rflAddr  (rflAddr),
      .rflAck   (rflAck),
      .rflDone  (rflDone),
      .rflData  (rflData),
      .memAddr  (memAddr),
      .memDout  (memDout),
      .memDin   (memDin),
      .memOe    (memOe),
      .memWe    (memWe)
   );

   initial fpgaClk = 1'b0;
   always #5 fpgaClk = ~fpgaClk;

   int checks = 0;
   int errors = 0;
   int tbSlot = 0;

   always @(posedge fpgaClk or negedge fpgaRstN) begin
      if (!fpgaRstN) tbSlot <= 0;
      else           tbSlot <= (tbSlot == 9) ? 0 : tbSlot + 1;
   end

   // Unwritten SRAM locations read back as an address-derived pattern.
   function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   logic              wrValid = 1'b0;
   logic [ADDR_W-1:0] wrAddr  = '0;
   logic [7:0]        wrData  = '0;

   always @(posedge fpgaClk) begin
      if (memWe) begin
         wrValid <= 1'b1;
         wrAddr  <= memAddr;
         wrData  <= memDout;
      end
   end

   assign memDin = (wrValid && memAddr == wrAddr) ? wrData : pat(memAddr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic gotoSlot(input int s);
      int n = 0;
      do begin
         @(negedge fpgaClk);
         n++;
      end while (tbSlot != s && n < 25);
      if (n >= 25) chk("slotTimeout", 32'(tbSlot), 32'(s));
   endtask

   initial begin
      fpgaRstN = 1'b1;
      cpuEn = 0; cpuRw = 0; cpuAddr = '0; cpuWdata = '0;
      vidReq = 0; vidAddr = '0; rflReq = 0; rflAddr = '0;
      #2 fpgaRstN = 1'b0;
      repeat (3) @(negedge fpgaClk);
      chk("rstPhi2", phi2, 0);
      chk("rstOe", memOe, 0);
      chk("rstWe", memWe, 0);
      chk("rstAddr", memAddr, 0);
      chk("rstRdata", cpuRdata, 0);
      chk("rstRflData", rflData, 0);
      fpgaRstN = 1'b1;

      // Idle: phi2 low in slots 0-4, high in 5-9, no SRAM strobes.
      for (int i = 0; i < 20; i++) begin
         @(negedge fpgaClk);
         chk("idlePhi2", phi2, (tbSlot >= 5));
         chk("idleOe", memOe, 0);
         chk("idleWe", memWe, 0);
      end

      // CPU write in window C, then read back.
      gotoSlot(4);
      cpuEn = 1; cpuRw = 0; cpuAddr = 24'h001234; cpuWdata = 8'hA5;
      gotoSlot(5);
      chk("wrAddr5", memAddr, 24'h001234);
      chk("wrDout5", memDout, 8'hA5);
      chk("wrWe5", memWe, 0);
      chk("wrOe5", memOe, 0);
      cpuEn = 0; cpuWdata = 8'h00;
      gotoSlot(6);
      chk("wrAddr6", memAddr, 24'h001234);
      chk("wrDout6", memDout, 8'hA5);
      chk("wrWe6", memWe, 1);
      gotoSlot(7);
      chk("wrWe7", memWe, 0);
      gotoSlot(4);
      cpuEn = 1; cpuRw = 1;
      gotoSlot(5);
      chk("rdAddr5", memAddr, 24'h001234);
      chk("rdOe5", memOe, 1);
      chk("rdWe5", memWe, 0);
      cpuEn = 0;
      gotoSlot(6);
      chk("rdData6", cpuRdata, 0);
      gotoSlot(7);
      chk("rdData7", cpuRdata, 8'hA5);

      // Video + refill + CPU all requesting.
      gotoSlot(9);
      vidReq = 1; vidAddr = 24'h000155;
      rflReq = 1; rflAddr = 24'h010000;
      cpuEn = 1; cpuRw = 1; cpuAddr = 24'h000200;
      for (int p = 0; p < 2; p++) begin
         gotoSlot(0);
         chk("vidAddrA", memAddr, 24'h000155);
         chk("vidOeA", memOe, 1);
         gotoSlot(2);
         chk("vidAck", vidAck, 1);
         chk("vidData", vidData, pat(24'h000155));
         chk("rflAddrB", memAddr, 24'h010000 + 2 * p);
         rflAddr = 24'h123456;
         gotoSlot(3);
         chk("vidAck3", vidAck, 0);
         gotoSlot(4);
         chk("rflAckB", rflAck, 1);
         chk("rflDataB", rflData, pat(24'(24'h010000 + 2 * p)));
         chk("rflDoneB", rflDone, 0);
         chk("turnOe4", memOe, 0);
         gotoSlot(5);
         chk("cpuAddrC", memAddr, 24'h000200);
         gotoSlot(7);
         chk("cpuRdC", cpuRdata, pat(24'h000200));
         chk("rflAddrD", memAddr, 24'h010001 + 2 * p);
         gotoSlot(9);
         chk("rflAckD", rflAck, 1);
         chk("rflDataD", rflData, pat(24'(24'h010001 + 2 * p)));
         chk("rflDoneD", rflDone, (p == 1));
      end

      // New burst uses the address presented after done.
      gotoSlot(0);
      chk("vidAddrA2", memAddr, 24'h000155);
      vidReq = 0; cpuEn = 0;
      gotoSlot(2);
      chk("newBase", memAddr, 24'h123456);
      rflReq = 0;
      gotoSlot(5);
      chk("newBeat1", memAddr, 24'h123457);
      gotoSlot(7);
      chk("newBeat2", memAddr, 24'h123458);
      gotoSlot(9);
      chk("newAck2", rflAck, 1);
      chk("newData2", rflData, pat(24'h123458));

      // Reset mid-burst.
      #1 fpgaRstN = 1'b0;
      #1;
      chk("midRstPhi2", phi2, 0);
      chk("midRstAck", rflAck, 0);
      chk("midRstData", rflData, 0);
      chk("midRstAddr", memAddr, 0);
      chk("midRstVid", vidData, 0);
      chk("midRstCpu", cpuRdata, 0);
      repeat (2) @(negedge fpgaClk);
      chk("midRstDone", rflDone, 0);
      fpgaRstN = 1'b1;
      chk("relPhi2", phi2, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge fpgaClk);
         chk("abortAck", rflAck, 0);
         chk("abortDone", rflDone, 0);
         chk("abortOe", memOe, 0);
      end

      // Top-of-memory burst wraps to 0, beats in A, B, C, D.
      gotoSlot(9);
      rflReq = 1; rflAddr = 24'hFFFFFE;
      gotoSlot(0);
      chk("wrapA", memAddr, 24'hFFFFFE);
      rflReq = 0; rflAddr = '0;
      gotoSlot(1);
      chk("wrapOe1", memOe, 1);
      gotoSlot(2);
      chk("wrapB", memAddr, 24'hFFFFFF);
      chk("wrapAckA", rflAck, 1);
      chk("wrapDataA", rflData, pat(24'hFFFFFE));
      chk("wrapNoVid", vidAck, 0);
      gotoSlot(4);
      chk("wrapAckB", rflAck, 1);
      chk("wrapDataB", rflData, pat(24'hFFFFFF));
      gotoSlot(5);
      chk("wrapC", memAddr, 24'h000000);
      gotoSlot(7);
      chk("wrapD", memAddr, 24'h000001);
      chk("wrapDataC", rflData, pat(24'h000000));
      chk("wrapDoneC", rflDone, 0);
      gotoSlot(9);
      chk("wrapAckD", rflAck, 1);
      chk("wrapDoneD", rflDone, 1);
      chk("wrapDataD", rflData, pat(24'h000001));
      gotoSlot(0);
      chk("wrapIdleOe", memOe, 0);
      gotoSlot(2);
      chk("wrapIdleAck", rflAck, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
